// File: rtl/icache_direct_mapped_pkg.sv
// ============================================================================
//  Module      : icache_direct_mapped_pkg
//  Description : Shared widths and FSM encoding for the direct-mapped I-cache.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_direct_mapped_pkg;

    localparam int IC_ADDR_W     = 10;
    localparam int IC_OFFSET_W   = 2;
    localparam int IC_INDEX_W    = 3;
    localparam int IC_TAG_W      = 3;
    localparam int IC_WORDS      = 1 << IC_OFFSET_W;
    localparam int IC_NUM_BLOCKS = 1 << IC_INDEX_W;
    localparam int IC_BLOCK_W    = 32 * IC_WORDS;

    typedef enum logic [1:0] {
        IC_IDLE     = 2'd0,
        IC_MEM_READ = 2'd1,
        IC_UPDATE   = 2'd2
    } ic_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_word_select.sv
// ============================================================================
//  Module      : icache_word_select
//  Description : Combinational word mux selecting one 32-bit word of a line.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_word_select #(
    parameter int WORDS    = 4,
    parameter int OFFSET_W = 2
) (
    input  logic [32*WORDS-1:0] line_i,
    input  logic [OFFSET_W-1:0] offset_i,
    output logic [31:0]         word_o
);

    logic [31:0] words [WORDS];

    for (genvar g = 0; g < WORDS; g++) begin : g_split
        assign words[g] = line_i[g*32 +: 32];
    end

    assign word_o = words[offset_i];

endmodule

`default_nettype wire

// File: rtl/icache_direct_mapped.sv
// ============================================================================
//  Module      : icache_direct_mapped
//  Description : Direct-mapped read-only instruction cache with block refill.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_direct_mapped
    import icache_direct_mapped_pkg::*;
#(
    parameter int ADDR_W          = IC_ADDR_W,
    parameter int NUM_BLOCKS      = IC_NUM_BLOCKS,
    parameter int WORDS_PER_BLOCK = IC_WORDS
) (
    input  logic                                             CLK,
    input  logic                                             RESET,
    input  logic [31:0]                                      PC,
    output logic [31:0]                                      INSTRUCTION,
    output logic                                             BUSYWAIT,
    output logic                                             MEM_READ,
    output logic [ADDR_W-3-$clog2(WORDS_PER_BLOCK):0]        MEM_ADDRESS,
    input  logic [32*WORDS_PER_BLOCK-1:0]                    MEM_READINST,
    input  logic                                             MEM_BUSYWAIT
);

    localparam int OFFSET_W = $clog2(WORDS_PER_BLOCK);
    localparam int INDEX_W  = $clog2(NUM_BLOCKS);
    localparam int TAG_W    = ADDR_W - 2 - OFFSET_W - INDEX_W;
    localparam int BA_W     = TAG_W + INDEX_W;
    localparam int BLOCK_W  = 32 * WORDS_PER_BLOCK;

    logic [OFFSET_W-1:0]   offset;
    logic [INDEX_W-1:0]    index;
    logic [TAG_W-1:0]      tag;
    logic                  unused_pc_bits;

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

    ic_state_e             state_q, state_d;
    logic [BA_W-1:0]       miss_q, miss_d;
    logic [31:0]           instr_q;

    logic [INDEX_W-1:0]    miss_idx;
    logic [TAG_W-1:0]      miss_tag;
    logic                  hit;
    logic                  fill;
    logic                  busy;
    logic                  mem_rd;
    logic [31:0]           word;

    assign offset         = PC[2 +: OFFSET_W];
    assign index          = PC[2+OFFSET_W +: INDEX_W];
    assign tag            = PC[2+OFFSET_W+INDEX_W +: TAG_W];
    assign unused_pc_bits = ^{PC[31:ADDR_W], PC[1:0]};

    assign miss_idx = miss_q[INDEX_W-1:0];
    assign miss_tag = miss_q[BA_W-1 -: TAG_W];
    assign hit      = valid_q[index] && (tag_q[index] == tag);
    assign fill     = (state_q == IC_MEM_READ) && !MEM_BUSYWAIT;

    icache_word_select #(
        .WORDS    (WORDS_PER_BLOCK),
        .OFFSET_W (OFFSET_W)
    ) u_word_select (
        .line_i   (data_q[index]),
        .offset_i (offset),
        .word_o   (word)
    );

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        busy    = 1'b1;
        mem_rd  = 1'b0;
        case (state_q)
            IC_IDLE: begin
                if (hit) begin
                    busy = 1'b0;
                end else begin
                    miss_d  = {tag, index};
                    state_d = IC_MEM_READ;
                end
            end
            IC_MEM_READ: begin
                mem_rd = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    state_d = IC_UPDATE;
                end
            end
            IC_UPDATE: begin
                state_d = IC_IDLE;
            end
            default: begin
                state_d = IC_IDLE;
            end
        endcase
    end

    // While reset is held every line is invalid, so the IDLE miss path would
    // otherwise raise a stall; the CPU must see a quiet interface instead.
    assign BUSYWAIT    = busy & RESET;
    assign MEM_READ    = mem_rd & RESET;
    assign MEM_ADDRESS = miss_q;
    assign INSTRUCTION = ((state_q == IC_IDLE) && hit) ? word : instr_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IC_IDLE;
            miss_q  <= '0;
            instr_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            instr_q <= INSTRUCTION;
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= MEM_READINST;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_icache_direct_mapped.sv
// ============================================================================
//  Module      : tb_icache_direct_mapped
//  Description : Scoreboard bench for the direct-mapped instruction cache.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_direct_mapped;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READINST;
    logic         MEM_BUSYWAIT;

    always #5 CLK = ~CLK;

    icache_direct_mapped dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READINST (MEM_READINST),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    typedef struct {
        logic [31:0] instr;
        int          pen;
        bit          rd;
        logic [5:0]  a0;
        logic [5:0]  a1;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_vec   = 0;
    int          n_err   = 0;
    int          mem_lat = 0;
    int          mem_cnt = 0;
    bit          trk     = 1'b0;
    int          hi_cyc  = 0;
    bit          rd_seen = 1'b0;
    logic [5:0]  a_first = '0;
    logic [5:0]  a_last  = '0;

    // Block 0 holds the 0x11..0x44 program; every other block a = word w
    // returns 32'hA000_0000 | a<<8 | w.
    function automatic logic [127:0] blk(input logic [5:0] a);
        logic [127:0] b;
        b = '0;
        if (a == 6'd0) begin
            b = {32'h44, 32'h33, 32'h22, 32'h11};
        end else begin
            for (int w = 0; w < 4; w++) begin
                b[w*32 +: 32] = 32'hA000_0000 | ({26'd0, a} << 8) | 32'(w);
            end
        end
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: mem_lat busy cycles after MEM_READ rises, then one data cycle.
    always @(negedge CLK) begin
        if (MEM_READ) begin
            if (mem_cnt < mem_lat) begin
                MEM_BUSYWAIT = 1'b1;
                MEM_READINST = {4{32'hDEAD_BEEF}};
            end else begin
                MEM_BUSYWAIT = 1'b0;
                MEM_READINST = blk(MEM_ADDRESS);
            end
            mem_cnt++;
        end else begin
            mem_cnt      = 0;
            MEM_BUSYWAIT = 1'b0;
        end
    end

    // Monitor: penalty = stall cycles minus one, i.e. rising edges that pass
    // before the edge at which BUSYWAIT falls.
    always @(negedge CLK) begin
        if (trk && RESET) begin
            if (MEM_READ) begin
                if (!rd_seen) a_first = MEM_ADDRESS;
                a_last  = MEM_ADDRESS;
                rd_seen = 1'b1;
            end
            if (BUSYWAIT) begin
                hi_cyc++;
            end else if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("instruction", INSTRUCTION, mon_e.instr);
                chk("miss_penalty", (hi_cyc == 0) ? 32'd0 : 32'(hi_cyc - 1), 32'(mon_e.pen));
                chk("mem_read_seen", {31'd0, rd_seen}, {31'd0, mon_e.rd});
                if (mon_e.rd) begin
                    chk("first_mem_address", {26'd0, a_first}, {26'd0, mon_e.a0});
                    chk("last_mem_address", {26'd0, a_last}, {26'd0, mon_e.a1});
                end
                trk = 1'b0;
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input logic [31:0] pc2, input int lat,
                         input logic [31:0] ins, input int pen, input bit rd,
                         input logic [5:0] a0, input logic [5:0] a1);
        exp_t e;
        mem_lat = lat;
        PC      = pc;
        e.instr = ins;
        e.pen   = pen;
        e.rd    = rd;
        e.a0    = a0;
        e.a1    = a1;
        q.push_back(e);
        hi_cyc  = 0;
        rd_seen = 1'b0;
        trk     = 1'b1;
        if (pc2 != pc) begin
            for (int i = 0; i < 50 && !MEM_READ; i++) @(negedge CLK);
            PC = pc2;
        end
        for (int i = 0; i < 100 && trk; i++) @(posedge CLK);
        if (trk) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: pc %h still stalled, expected instruction %h", pc, ins);
            trk = 1'b0;
            q.delete();
        end
        #1;
    endtask

    initial begin
        RESET        = 1'b0;
        PC           = 32'h0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READINST = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_instruction", INSTRUCTION, 32'h0);
        chk("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
        RESET = 1'b1;

        // Cold miss, then same-line hits on successive cycles
        fetch(32'd0,  32'd0,  5, 32'h11, 7, 1'b1, 6'd0, 6'd0);
        fetch(32'd4,  32'd4,  5, 32'h22, 0, 1'b0, 6'd0, 6'd0);
        fetch(32'd8,  32'd8,  5, 32'h33, 0, 1'b0, 6'd0, 6'd0);
        fetch(32'd12, 32'd12, 5, 32'h44, 0, 1'b0, 6'd0, 6'd0);

        // Conflict miss on index 0
        fetch(32'd128, 32'd128, 2, 32'hA000_0800, 4, 1'b1, 6'd8, 6'd8);
        fetch(32'd132, 32'd132, 2, 32'hA000_0801, 0, 1'b0, 6'd0, 6'd0);
        fetch(32'd0,   32'd0,   2, 32'h11,        4, 1'b1, 6'd0, 6'd0);

        // Asynchronous reset in the middle of the refill for PC=16
        mem_lat = 3;
        PC      = 32'd16;
        for (int i = 0; i < 20 && !MEM_READ; i++) @(negedge CLK);
        chk("mem_read_before_reset", {31'd0, MEM_READ}, 32'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        PC    = 32'd0;
        #1;
        chk("reset_pulse_mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("reset_pulse_busywait", {31'd0, BUSYWAIT}, 32'd0);
        chk("reset_pulse_instruction", INSTRUCTION, 32'h0);
        #2;
        RESET = 1'b1;
        fetch(32'd0, 32'd0, 3, 32'h11, 5, 1'b1, 6'd0, 6'd0);

        // High PC bits alias onto the cached line
        fetch(32'h0000_0404, 32'h0000_0404, 3, 32'h22, 0, 1'b0, 6'd0, 6'd0);
        fetch(32'hFFFF_FC00, 32'hFFFF_FC00, 3, 32'h11, 0, 1'b0, 6'd0, 6'd0);

        // PC moves from 32 to 48 mid-refill: line 2 completes, then line 3 fills
        fetch(32'd32, 32'd48, 2, 32'hA000_0300, 9, 1'b1, 6'd2, 6'd3);
        fetch(32'd32, 32'd32, 2, 32'hA000_0200, 0, 1'b0, 6'd0, 6'd0);
        fetch(32'd52, 32'd52, 2, 32'hA000_0301, 0, 1'b0, 6'd0, 6'd0);

        // Zero-wait memory
        fetch(32'd200,  32'd200,  0, 32'hA000_0C02, 2, 1'b1, 6'd12, 6'd12);
        fetch(32'd1020, 32'd1020, 0, 32'hA000_3F03, 2, 1'b1, 6'd63, 6'd63);
        fetch(32'd204,  32'd204,  0, 32'hA000_0C03, 0, 1'b0, 6'd0,  6'd0);

        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port (PC in, INSTRUCTION out) and a block-organised instruction memory.
- Replaces the flat byte-array fetch path.
- Serves hits combinationally in the same cycle.
- On a miss it stalls the CPU via BUSYWAIT and refills the whole block from memory through a 3-state FSM.

Parameters:
- ADDR_W, 10, byte-address bits used from PC (1 KiB instruction space).
- NUM_BLOCKS, 8, cache lines; power of two.
- WORDS_PER_BLOCK, 4, 32-bit words per line (16-byte lines).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PC  in  32  CPU fetch byte address; only PC[ADDR_W-1:0] is used.
- INSTRUCTION  out  32  fetched instruction word, valid when BUSYWAIT=0.
- BUSYWAIT  out  1  stall request to the CPU; the PC must not advance while it is 1.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  ADDR_W-4 (6)  block address {tag,index}.
- MEM_READINST  in  32*WORDS_PER_BLOCK (128)  returned block; word0 is in bits [31:0].
- MEM_BUSYWAIT  in  1  memory is busy; data is valid in the cycle it falls to 0 while MEM_READ=1.

Behaviour:
- Address split for the defaults:
  - offset = PC[3:2]
  - index = PC[6:4]
  - tag = PC[9:7]
  - PC[1:0] is ignored (word-aligned fetch).
- Storage: per line, valid bit, 3-bit tag and 128-bit data, all in flops.
- Hit = valid[index] AND tag[index]==tag. Hit logic is combinational.
- Reset (RESET=0, asynchronous):
  - all valid bits cleared, state=IDLE, miss-address register cleared;
  - MEM_READ=0, BUSYWAIT=0, INSTRUCTION=32'h0;
  - tag and data arrays are not cleared.
- State IDLE:
  - On a hit: INSTRUCTION = data[index][offset*32 +: 32], BUSYWAIT=0, same cycle, zero-cycle latency.
  - On a miss: BUSYWAIT=1 combinationally, {tag,index} latched into the miss register at the next edge, next state MEM_READ.
- State MEM_READ:
  - MEM_READ=1, MEM_ADDRESS = miss register, BUSYWAIT=1.
  - Stay while MEM_BUSYWAIT=1.
  - At the edge where MEM_BUSYWAIT=0: capture MEM_READINST into the line addressed by the miss register, set its tag and valid=1, next state UPDATE.
- State UPDATE:
  - MEM_READ=0, BUSYWAIT=1 (one settle cycle); next state IDLE unconditionally.
  - The hit is then served in IDLE.
- Miss penalty: 1 (detect) + N (memory busy cycles) + 1 (UPDATE) rising edges before BUSYWAIT falls.
- The fill always targets the latched miss address. A PC change during MEM_READ/UPDATE is a CPU protocol violation. It must not corrupt the fill; the new PC is evaluated only on return to IDLE.
- A reset asserted mid-refill aborts immediately:
  - MEM_READ drops asynchronously;
  - the partially returned data is discarded;
  - all lines are invalid afterwards.
- A miss on a valid line overwrites it; no write-back, since the cache is read-only.
- PC values above 1023 alias on the low ADDR_W bits; no error is raised.
- INSTRUCTION holds its last driven value while BUSYWAIT=1 (no X propagation).
- No # delays in the RTL. Timing is purely cycle-based so the block synthesises.

Decomposition:
- Shared package/header holds:
  - IC_ADDR_W, IC_OFFSET_W (2), IC_INDEX_W (3), IC_TAG_W (3), IC_BLOCK_W (128);
  - FSM state encodings IC_IDLE=2'd0, IC_MEM_READ=2'd1, IC_UPDATE=2'd2.
- One natural sub-module, icache_word_select: a combinational 4:1 word mux from the 128-bit line by offset.
- The FSM and arrays stay in the top module.

Test Plan:
- Cold fetch PC=0, memory latency 5 cycles, block0 = {32'h44,32'h33,32'h22,32'h11} → BUSYWAIT high for 7 edges, MEM_ADDRESS=6'd0 while MEM_READ=1, then INSTRUCTION=32'h11 with BUSYWAIT=0.
- After that fill, PC=4,8,12 on successive cycles → INSTRUCTION 32'h22, 32'h33, 32'h44; BUSYWAIT stays 0; MEM_READ is never asserted.
- Conflict miss: PC=0 is filled, then PC=128 (same index 0, tag 1) → refill with MEM_ADDRESS=6'd8. A return to PC=0 misses again and refetches with MEM_ADDRESS=6'd0.
- RESET=0 pulsed for 3 ns during MEM_READ of PC=16 → MEM_READ and BUSYWAIT drop within the pulse (asynchronous). A subsequent fetch of previously cached PC=0 misses (valid cleared).
- PC toggled from 32 to 48 during the MEM_READ of 32 → the line for 32 completes (valid, tag correct). Line index 3 is then filled for 48 before its INSTRUCTION is served.
- Zero-wait memory (MEM_BUSYWAIT=0 throughout) → miss penalty is exactly 2 edges and data is correct.
